// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states
// and the alignment/legality rule.
package mem_access_pkg;
   localparam int DATA_W = 32;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0010;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Illegal op codes are folded into the misaligned path so they never touch memory.
   function automatic logic op_bad(input logic [3:0] op, input logic [1:0] a);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_bad = 1'b0;
         OP_LH, OP_LHU, OP_SH: op_bad = a[0];
         OP_LW, OP_SW:         op_bad = |a;
         default:              op_bad = 1'b1;
      endcase
   endfunction
endpackage

// File: rtl/lane_merge_extend.sv
// Little-endian lane handling: inserts store data into a read word and
// extracts/extends the addressed lane for loads.
module lane_merge_extend
   import mem_access_pkg::*;
(
   input  logic [3:0]        i_op,
   input  logic [1:0]        i_lane,
   input  logic [DATA_W-1:0] i_word,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_merged,
   output logic [DATA_W-1:0] o_load
);
   logic [4:0]  w_bsel;
   logic [4:0]  w_hsel;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sgn;

   always_comb begin
      w_bsel   = {i_lane, 3'b000};
      w_hsel   = {i_lane[1], 4'b0000};
      w_byte   = i_word[w_bsel +: 8];
      w_half   = i_word[w_hsel +: 16];
      w_sgn    = ~i_op[2];
      o_merged = i_word;
      o_load   = i_word;
      case (i_op[1:0])
         2'b00: begin
            o_merged[w_bsel +: 8] = i_wdata[7:0];
            o_load = {{24{w_byte[7] & w_sgn}}, w_byte};
         end
         2'b01: begin
            o_merged[w_hsel +: 16] = i_wdata[15:0];
            o_load = {{16{w_half[15] & w_sgn}}, w_half};
         end
         default: begin
            o_merged = i_wdata;
            o_load   = i_word;
         end
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: byte/half/word accesses to a word-addressed
// memory, read-modify-write for sub-word stores, all outputs registered.
module mem_access_unit #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [3:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] load_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_w,
   output logic              mem_r,
   input  logic [DATA_W-1:0] mem_rd
);
   import mem_access_pkg::*;

   state_t              r_state, w_next;
   logic [3:0]          r_op, w_op;
   logic [1:0]          r_lane, w_lane;
   logic [DATA_W-1:0]   r_wdata, w_wdata;
   logic                r_busy, r_done, r_err, r_mem_w, r_mem_r;
   logic                w_busy, w_done, w_err, w_mem_w, w_mem_r;
   logic [DATA_W-1:0]   r_load, w_load, r_wd, w_wd;
   logic [ADDR_W-1:0]   r_addr, w_addr;
   logic [DATA_W-1:0]   w_merged, w_ext;
   logic                w_bad, w_accept;
   logic                w_unused;

   assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};
   assign w_bad    = op_bad(req_op, req_addr[1:0]);
   assign w_accept = (r_state == ST_IDLE) && req;

   lane_merge_extend u_lane (
      .i_op    (r_op),
      .i_lane  (r_lane),
      .i_word  (mem_rd),
      .i_wdata (r_wdata),
      .o_merged(w_merged),
      .o_load  (w_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
         r_lane  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_mem_w <= 1'b0;
         r_mem_r <= 1'b0;
         r_load  <= '0;
         r_addr  <= '0;
         r_wd    <= '0;
      end else begin
         r_state <= w_next;
         r_op    <= w_op;
         r_lane  <= w_lane;
         r_wdata <= w_wdata;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_err   <= w_err;
         r_mem_w <= w_mem_w;
         r_mem_r <= w_mem_r;
         r_load  <= w_load;
         r_addr  <= w_addr;
         r_wd    <= w_wd;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               if (w_bad)                w_next = ST_DONE;
               else if (req_op == OP_SW) w_next = ST_WRITE;
               else                      w_next = ST_READ;
            end
         end
         ST_READ:  w_next = r_op[3] ? ST_WRITE : ST_DONE;
         ST_WRITE: w_next = ST_DONE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Next values for every registered output; strobes follow the next state.
   always_comb begin
      w_busy  = (w_next == ST_READ) || (w_next == ST_WRITE);
      w_done  = (w_next == ST_DONE);
      w_mem_r = (w_next == ST_READ);
      w_mem_w = (w_next == ST_WRITE);
      w_err   = w_accept && w_bad;
      w_op    = r_op;
      w_lane  = r_lane;
      w_wdata = r_wdata;
      w_addr  = r_addr;
      w_wd    = r_wd;
      w_load  = r_load;
      if (w_accept) begin
         w_op    = req_op;
         w_lane  = req_addr[1:0];
         w_wdata = req_wdata;
         w_addr  = req_addr[ADDR_W+1:2];
         if (!w_bad && req_op == OP_SW) w_wd = req_wdata;
      end
      if (r_state == ST_READ) begin
         if (r_op[3]) w_wd   = w_merged;
         else         w_load = w_ext;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign load_data = r_load;
   assign mem_addr  = r_addr;
   assign mem_wd    = r_wd;
   assign mem_w     = r_mem_w;
   assign mem_r     = r_mem_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural memory.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic        clk, rst, req;
   logic [3:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        busy, done, err, mem_w, mem_r;
   logic [31:0] load_data, mem_wd, mem_rd;
   logic [4:0]  mem_addr;

   logic [31:0] mem [32];
   int          n_total, n_pass, n_fail;
   int          lat, nr, nw, both;
   logic [31:0] wd_seen, ld_seen;
   logic        err_seen, done_seen;

   mem_access_unit #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
      .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
      .load_data(load_data), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_w(mem_w), .mem_r(mem_r), .mem_rd(mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd = mem[mem_addr];
   always @(posedge clk) if (mem_w) mem[mem_addr] <= mem_wd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
      req = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   // Starts just after the accepting edge; leaves the DUT back in IDLE.
   task automatic run_to_done();
      nr = 0; nw = 0; both = 0; wd_seen = '0;
      done_seen = 1'b0; err_seen = 1'b0; ld_seen = '0; lat = 0;
      for (int c = 1; c <= 10; c++) begin
         lat = c;
         if (mem_r) nr++;
         if (mem_w) begin nw++; wd_seen = mem_wd; end
         if (mem_r && mem_w) both++;
         if (done) begin
            done_seen = 1'b1; err_seen = err; ld_seen = load_data;
            break;
         end
         @(posedge clk); #1;
      end
      check("done_seen", {31'b0, done_seen}, 32'd1);
      check("no_r_and_w", both, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      n_total = 0; n_pass = 0; n_fail = 0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
      mem[0] = 32'h0000_0123;
      mem[1] = 32'h1122_3344;
      mem[2] = 32'hCAFE_F00D;
      mem[3] = 32'h8070_F0A5;
      rst = 1'b1; req = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", {busy, done, err, mem_w, mem_r}, 32'd0);
      check("rst_load", load_data, 32'd0);
      check("rst_addr", {27'd0, mem_addr}, 32'd0);
      check("rst_wd", mem_wd, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(OP_LB, 32'h0C, 32'h0); run_to_done();
      check("lb_data", ld_seen, 32'hFFFF_FFA5);
      check("lb_lat", lat, 2);
      check("lb_err", {31'b0, err_seen}, 32'd0);
      check("lb_strobes", {nr[15:0], nw[15:0]}, {16'd1, 16'd0});

      issue(OP_LHU, 32'h0E, 32'h0); run_to_done();
      check("lhu_data", ld_seen, 32'h0000_8070);
      issue(OP_LH, 32'h0E, 32'h0); run_to_done();
      check("lh_data", ld_seen, 32'hFFFF_8070);
      issue(OP_LBU, 32'h0D, 32'h0); run_to_done();
      check("lbu_data", ld_seen, 32'h0000_00F0);
      check("load_held", load_data, 32'h0000_00F0);

      issue(OP_SB, 32'h0D, 32'h0000_0011); run_to_done();
      check("sb_lat", lat, 3);
      check("sb_strobes", {nr[15:0], nw[15:0]}, {16'd1, 16'd1});
      check("sb_wd", wd_seen, 32'h8070_11A5);
      issue(OP_LW, 32'h0C, 32'h0); run_to_done();
      check("sb_readback", ld_seen, 32'h8070_11A5);

      issue(OP_SW, 32'h7C, 32'hDEAD_BEEF); run_to_done();
      check("sw_lat", lat, 2);
      check("sw_strobes", {nr[15:0], nw[15:0]}, {16'd0, 16'd1});
      issue(OP_LW, 32'h7C, 32'h0); run_to_done();
      check("sw_readback", ld_seen, 32'hDEAD_BEEF);
      issue(OP_LW, 32'h80, 32'h0); run_to_done();
      check("lw_wrap", ld_seen, 32'h0000_0123);

      issue(OP_LW, 32'h0E, 32'h0); run_to_done();
      check("lw_mis_err", {31'b0, err_seen}, 32'd1);
      check("lw_mis_lat", lat, 1);
      check("lw_mis_strobes", {nr[15:0], nw[15:0]}, 32'd0);
      issue(OP_SH, 32'h0D, 32'h0); run_to_done();
      check("sh_mis_err", {31'b0, err_seen}, 32'd1);
      check("sh_mis_lat", lat, 1);
      check("sh_mis_strobes", {nr[15:0], nw[15:0]}, 32'd0);
      issue(4'b0011, 32'h10, 32'h0); run_to_done();
      check("illegal_err", {31'b0, err_seen}, 32'd1);
      check("illegal_strobes", {nr[15:0], nw[15:0]}, 32'd0);
      issue(OP_LW, 32'h10, 32'h0); run_to_done();
      check("err_cleared", {31'b0, err_seen}, 32'd0);

      // SH with req held into busy and store data changed after acceptance.
      req = 1'b1; req_op = OP_SH; req_addr = 32'h06; req_wdata = 32'h0000_BEEF;
      @(posedge clk); #1;
      check("held_busy", {31'b0, busy}, 32'd1);
      req_wdata = 32'h0000_FFFF;
      run_to_done();
      req = 1'b0;
      check("held_lat", lat, 3);
      check("held_strobes", {nr[15:0], nw[15:0]}, {16'd1, 16'd1});
      check("held_wd", wd_seen, 32'hBEEF_3344);
      repeat (2) @(posedge clk);
      #1;
      check("held_idle", {busy, done, mem_r, mem_w}, 32'd0);
      check("held_mem", mem[1], 32'hBEEF_3344);

      // Reset while the SH is in READ.
      issue(OP_SH, 32'h08, 32'h0000_5555);
      check("rmw_in_read", {31'b0, mem_r}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ctrl", {busy, done, err, mem_w, mem_r}, 32'd0);
      check("abort_load", load_data, 32'd0);
      check("abort_addr_wd", {27'd0, mem_addr} | mem_wd, 32'd0);
      nw = 0;
      for (int c = 0; c < 4; c++) begin
         if (mem_w) nw++;
         @(posedge clk); #1;
      end
      check("abort_no_w", nw, 0);
      check("abort_mem", mem[2], 32'hCAFE_F00D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
